usb_port_poll_scheduler: RTL and testbench

Round-robin downstream-port poll scheduler for the USB hub. It is the parametrised successor to the fixed polling clock generator and sits between the per-port speed detectors and trans-receivers. It grants one port at a time a fixed-length poll slot and skips ports that are disabled or disconnected. A port that is still driving at slot end may extend its slot, bounded by a timeout.

---
 rtl/usb_port_poll_scheduler.sv | 96 +++++++++
 tb/tb_usb_port_poll_scheduler.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/usb_port_poll_scheduler.sv
// usb_port_poll_scheduler: round-robin poll slot scheduler skipping ineligible ports, with bounded busy hold.
module usb_port_poll_scheduler #(
  parameter int NUM_PORTS      = 2,
  parameter int SLOT_CYCLES    = 30,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] port_enable,
  input  logic [NUM_PORTS-1:0] port_connected,
  input  logic [NUM_PORTS-1:0] port_busy,
  output logic [NUM_PORTS-1:0] poll_strobe,
  output logic [NUM_PORTS-1:0] slot_active,
  output logic [((NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1)-1:0] cur_port,
  output logic [NUM_PORTS-1:0] slot_timeout,
  output logic                 idle
);
  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int MAXC  = (SLOT_CYCLES > TIMEOUT_CYCLES) ? SLOT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW    = $clog2(MAXC + 1);
  localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, SELECT, SLOT, HOLD} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [IDX_W-1:0] last_port, sel, grant_idx;
  logic [NUM_PORTS-1:0] elig, onehot, active_nxt, strobe_nxt, timeout_nxt;
  logic found, cur_elig, cur_busy;
  assign elig     = port_enable & port_connected;
  assign cur_elig = elig[cur_port];
  assign cur_busy = port_busy[cur_port];
  assign idle     = (state == IDLE);
  // Circular search starting just after the last granted port.
  always_comb begin
    found = 1'b0;
    sel   = last_port;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      int j;
      j = (int'(last_port) + k) % NUM_PORTS;
      if (!found && elig[j]) begin
        found = 1'b1;
        sel   = IDX_W'(j);
      end
    end
  end
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE:   state_nxt = |elig ? SELECT : IDLE;
      SELECT: begin
        state_nxt = found ? SLOT : IDLE;
        cnt_nxt   = '0;
      end
      SLOT:
        if (cnt == SLOT_LAST) begin
          state_nxt = cur_busy ? HOLD : SELECT;
          cnt_nxt   = '0;
        end else if (!cur_elig && !cur_busy) state_nxt = SELECT;
        else cnt_nxt = cnt + 1'b1;
      HOLD:
        if (!cur_busy || !cur_elig || cnt == TO_LAST) state_nxt = SELECT;
        else cnt_nxt = cnt + 1'b1;
      default: state_nxt = IDLE;
    endcase
  end
  // Output values for the coming cycle; the timeout pulse lands in the last hold cycle.
  always_comb begin
    grant_idx   = (state == SELECT) ? sel : cur_port;
    onehot      = NUM_PORTS'(1) << grant_idx;
    active_nxt  = (state_nxt == SLOT || state_nxt == HOLD) ? onehot : '0;
    strobe_nxt  = (state == SELECT && found) ? onehot : '0;
    timeout_nxt = (state_nxt == HOLD && cnt_nxt == TO_LAST && cur_busy && cur_elig) ? onehot : '0;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      last_port    <= IDX_W'(NUM_PORTS - 1);
      cur_port     <= '0;
      slot_active  <= '0;
      poll_strobe  <= '0;
      slot_timeout <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      slot_active  <= active_nxt;
      poll_strobe  <= strobe_nxt;
      slot_timeout <= timeout_nxt;
      if (state == SELECT && found) begin
        last_port <= sel;
        cur_port  <= sel;
      end
    end
  end
endmodule

// File: tb/tb_usb_port_poll_scheduler.sv
// tb_usb_port_poll_scheduler: directed and randomized checks against a slot-age based reference model.
module tb_usb_port_poll_scheduler;
  localparam int N = 4, S = 4, T = 8;
  logic clock = 1'b0, reset = 1'b1;
  logic [N-1:0] port_enable, port_connected, port_busy;
  logic [N-1:0] poll_strobe, slot_active, slot_timeout;
  logic [1:0] cur_port;
  logic idle;
  int checks = 0, errors = 0;
  int ph, age, mp, ml;
  logic [N-1:0] m_to;

  usb_port_poll_scheduler #(.NUM_PORTS(N), .SLOT_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clock(clock), .reset(reset), .port_enable(port_enable), .port_connected(port_connected),
    .port_busy(port_busy), .poll_strobe(poll_strobe), .slot_active(slot_active),
    .cur_port(cur_port), .slot_timeout(slot_timeout), .idle(idle)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ph: 0 idle, 1 selecting, 2 granted; age counts cycles since the grant, hold starts at age S.
  task automatic m_reset;
    ph = 0; age = 0; mp = 0; ml = N - 1; m_to = '0;
  endtask

  task automatic m_step;
    logic [N-1:0] e;
    bit pe, pb, adv;
    e = port_enable & port_connected;
    m_to = '0;
    adv = 0;
    if (ph == 0) begin
      if (e != 0) ph = 1;
    end else if (ph == 1) begin
      ph = 0;
      for (int k = 1; k <= N; k++) begin
        int p;
        p = (ml + k) % N;
        if (ph == 0 && e[p]) begin ph = 2; mp = p; ml = p; age = 0; end
      end
    end else begin
      pe = e[mp];
      pb = port_busy[mp];
      if (age < S - 1) begin
        if (!pe && !pb) ph = 1; else adv = 1;
      end else if (age == S - 1) begin
        if (pb) adv = 1; else ph = 1;
      end else begin
        if (!pb || !pe || age == S + T - 1) ph = 1; else adv = 1;
      end
      if (adv) begin
        age++;
        if (age == S + T - 1 && pe) m_to = N'(1) << mp;
      end
    end
  endtask

  task automatic compare;
    logic [N-1:0] act, stb;
    act = (ph == 2) ? N'(1) << mp : '0;
    stb = (ph == 2 && age == 0) ? N'(1) << mp : '0;
    check("slot_active", slot_active, act);
    check("poll_strobe", poll_strobe, stb);
    check("slot_timeout", slot_timeout, m_to);
    check("idle", idle, ph == 0);
    check("cur_port", cur_port, mp);
    check("onehot", $onehot0(slot_active) && $onehot0(poll_strobe) && $onehot0(slot_timeout), 1);
  endtask

  task automatic cycle;
    @(posedge clock);
    m_step;
    @(negedge clock);
    compare;
  endtask

  initial begin
    bit hit;
    port_enable = '0; port_connected = '0; port_busy = '0;
    m_reset;
    repeat (2) @(negedge clock);
    compare;
    // All ports eligible straight out of reset: 5-cycle slot+gap per port.
    reset = 1'b0;
    port_enable = '1; port_connected = '1;
    for (int c = 1; c <= 22; c++) begin
      cycle;
      if (c == 2)  check("t1_first_strobe", poll_strobe, 4'b0001);
      if (c == 7)  check("t1_second_strobe", poll_strobe, 4'b0010);
      if (c == 22) check("t1_wrap_strobe", poll_strobe, 4'b0001);
    end
    // Alternating mask, then re-enable port 0.
    port_enable = 4'b1010;
    repeat (20) cycle;
    port_enable = 4'b1011;
    repeat (12) cycle;
    // Stuck busy on port 1 to force timeouts.
    port_enable = '1; port_busy = 4'b0010;
    hit = 0;
    for (int c = 0; c < 80; c++) begin
      cycle;
      if (slot_timeout != 0) hit = 1;
    end
    check("t4_timeout_seen", hit, 1);
    // Disconnect everything: scheduler parks in IDLE.
    port_busy = '0; port_connected = '0;
    repeat (8) cycle;
    check("t5_idle", idle, 1);
    // Reach a hold, then reset asynchronously between edges.
    port_connected = '1; port_busy = '1;
    hit = 0;
    for (int c = 0; c < 40 && !hit; c++) begin
      cycle;
      if (ph == 2 && age >= S) hit = 1;
    end
    check("t6_hold_reached", hit, 1);
    #2 reset = 1'b1;
    #1;
    check("t6_async_active", slot_active, 0);
    check("t6_async_strobe", poll_strobe, 0);
    check("t6_async_timeout", slot_timeout, 0);
    check("t6_async_idle", idle, 1);
    m_reset;
    @(negedge clock);
    compare;
    reset = 1'b0;
    port_busy = '0;
    cycle;
    cycle;
    check("t6_first_grant", poll_strobe, 4'b0001);
    // Randomized traffic with persistent busy levels.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(15) == 0) port_enable[$urandom_range(N - 1)] ^= 1'b1;
      if ($urandom_range(23) == 0) port_connected[$urandom_range(N - 1)] ^= 1'b1;
      if ($urandom_range(7) == 0) port_busy[$urandom_range(N - 1)] ^= 1'b1;
      if ($urandom_range(400) == 0) begin
        port_enable = '1; port_connected = '1;
      end
      cycle;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
